// File: rtl/jacobi_matrix_loader.sv
// Streams an N x N matrix (row-major, valid/ready) into port A of the Jacobi matrix RAM,
// then holds it until the core releases it. Define JACOBI_SYM_MIRROR_EN for upper-triangle + port-B mirroring.
module jacobi_matrix_loader #(
  parameter int ADDR_WIDTH = 7,
  parameter int MEM_SIZE   = 128,
  parameter int DATA_WIDTH = 20,
  parameter int N          = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_last,
  output logic                  ram_en_a,
  output logic                  ram_we_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_din_a,
  output logic                  ram_en_b,
  output logic                  ram_we_b,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic [DATA_WIDTH-1:0] ram_din_b,
  output logic                  mem_full,
  output logic                  frame_done,
  output logic                  frame_err,
  input  logic                  mem_release
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]         LASTI = CW'(N - 1);
  localparam logic [ADDR_WIDTH-1:0] NA    = ADDR_WIDTH'(N);

  if (N * N > MEM_SIZE) begin : g_bad_size
    $error("jacobi_matrix_loader: N*N exceeds MEM_SIZE");
  end

  typedef enum logic {LOAD, FULL} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]         row, col;
  logic [ADDR_WIDTH-1:0] addr_rc;
  logic                  beat, last_beat;

  assign addr_rc   = ADDR_WIDTH'(row) * NA + ADDR_WIDTH'(col);
  assign last_beat = (row == LASTI) && (col == LASTI);
  // Gate with rst_n so the stream sees no ready while the block is held in reset.
  assign s_ready   = rst_n && (state == LOAD);
  assign beat      = s_valid && s_ready;
  assign mem_full  = (state == FULL);

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD: if (beat && last_beat) state_nxt = FULL;
      FULL: if (mem_release)       state_nxt = LOAD;
      default:                     state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD;
      row        <= '0;
      col        <= '0;
      ram_en_a   <= 1'b0;
      ram_we_a   <= 1'b0;
      ram_addr_a <= '0;
      ram_din_a  <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      ram_en_a   <= beat;
      ram_we_a   <= beat;
      frame_done <= beat && last_beat;
      if (beat) begin
        ram_addr_a <= addr_rc;
        ram_din_a  <= s_data;
        if (s_last != last_beat) frame_err <= 1'b1;
        if (last_beat) begin
          row <= '0;
          col <= '0;
        end else if (col == LASTI) begin
          row <= row + 1'b1;
`ifdef JACOBI_SYM_MIRROR_EN
          col <= row + 1'b1;  // next row starts on its diagonal
`else
          col <= '0;
`endif
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

`ifdef JACOBI_SYM_MIRROR_EN
  logic [ADDR_WIDTH-1:0] addr_cr;
  assign addr_cr = ADDR_WIDTH'(col) * NA + ADDR_WIDTH'(row);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en_b   <= 1'b0;
      ram_we_b   <= 1'b0;
      ram_addr_b <= '0;
      ram_din_b  <= '0;
    end else begin
      ram_en_b <= beat && (row != col);
      ram_we_b <= beat && (row != col);
      if (beat && (row != col)) begin
        ram_addr_b <= addr_cr;
        ram_din_b  <= s_data;
      end
    end
  end
`else
  assign ram_en_b   = 1'b0;
  assign ram_we_b   = 1'b0;
  assign ram_addr_b = '0;
  assign ram_din_b  = '0;
`endif
endmodule

// File: tb/tb_jacobi_matrix_loader.sv
// Directed bench for jacobi_matrix_loader (N=4): beat-indexed reference model checked every cycle,
// plus a RAM image and literal expectations for the frame contents.
module tb_jacobi_matrix_loader;
  localparam int AW = 7, DW = 20, N = 4;
`ifdef JACOBI_SYM_MIRROR_EN
  localparam int NB = N * (N + 1) / 2;
`else
  localparam int NB = N * N;
`endif

  logic          clk = 1'b0, rst_n;
  logic [DW-1:0] s_data;
  logic          s_valid, s_ready, s_last;
  logic          ram_en_a, ram_we_a, ram_en_b, ram_we_b;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [DW-1:0] ram_din_a, ram_din_b;
  logic          mem_full, frame_done, frame_err, mem_release;

  jacobi_matrix_loader #(.ADDR_WIDTH(AW), .MEM_SIZE(128), .DATA_WIDTH(DW), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .s_last(s_last), .ram_en_a(ram_en_a), .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a),
    .ram_din_a(ram_din_a), .ram_en_b(ram_en_b), .ram_we_b(ram_we_b), .ram_addr_b(ram_addr_b),
    .ram_din_b(ram_din_b), .mem_full(mem_full), .frame_done(frame_done),
    .frame_err(frame_err), .mem_release(mem_release));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Beat k -> (row,col) -> addresses, enumerated straight from the stream order.
  int tab_a[NB], tab_b[NB];
  bit tab_be[NB];
  initial begin
    int k = 0;
    for (int r = 0; r < N; r++) begin
`ifdef JACOBI_SYM_MIRROR_EN
      for (int c = r; c < N; c++) begin
`else
      for (int c = 0; c < N; c++) begin
`endif
        tab_a[k] = r * N + c;
        tab_b[k] = c * N + r;
`ifdef JACOBI_SYM_MIRROR_EN
        tab_be[k] = (r != c);
`else
        tab_be[k] = 1'b0;
`endif
        k++;
      end
    end
  end

  // Reference model: beat counter, ownership flag, expected registered writes.
  bit m_load, m_err, x_en_a, x_en_b, x_done;
  int m_k, x_addr_a, x_addr_b;
  logic [DW-1:0] x_din;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_load <= 1; m_k <= 0; m_err <= 0; x_en_a <= 0; x_en_b <= 0; x_done <= 0;
    end else begin
      x_en_a <= 0; x_en_b <= 0; x_done <= 0;
      if (m_load && s_valid) begin
        x_en_a <= 1; x_addr_a <= tab_a[m_k]; x_din <= s_data;
        x_en_b <= tab_be[m_k]; x_addr_b <= tab_b[m_k];
        if (s_last != (m_k == NB - 1)) m_err <= 1;
        if (m_k == NB - 1) begin m_k <= 0; m_load <= 0; x_done <= 1; end
        else m_k <= m_k + 1;
      end else if (!m_load && mem_release) m_load <= 1;
    end
  end

  // RAM image written from the DUT ports, plus event counters.
  logic [DW-1:0] ram_img[128];
  int wr_cnt = 0, done_cnt = 0;
  always @(posedge clk) begin
    if (ram_en_a && ram_we_a) begin ram_img[ram_addr_a] <= ram_din_a; wr_cnt <= wr_cnt + 1; end
    if (ram_en_b && ram_we_b) ram_img[ram_addr_b] <= ram_din_b;
  end

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    chk("s_ready",    s_ready,    rst_n && m_load);
    chk("ram_en_a",   ram_en_a,   x_en_a);
    chk("ram_we_a",   ram_we_a,   x_en_a);
    chk("ram_en_b",   ram_en_b,   x_en_b);
    chk("ram_we_b",   ram_we_b,   x_en_b);
    chk("mem_full",   mem_full,   rst_n && !m_load);
    chk("frame_done", frame_done, x_done);
    chk("frame_err",  frame_err,  m_err);
    if (x_en_a) begin
      chk("ram_addr_a", ram_addr_a, x_addr_a);
      chk("ram_din_a",  ram_din_a,  x_din);
    end
    if (x_en_b) begin
      chk("ram_addr_b", ram_addr_b, x_addr_b);
      chk("ram_din_b",  ram_din_b,  x_din);
    end
  end

  task automatic send(input int d, input bit last);
    s_valid = 1; s_data = DW'(d); s_last = last;
    @(posedge clk); #1;
    s_valid = 0; s_last = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int wr0;
    rst_n = 0; s_valid = 0; s_last = 0; s_data = '0; mem_release = 0;
    cyc(3);
    rst_n = 1;

    // Frame 1: back-to-back, correct s_last.
    for (int k = 0; k < NB; k++) send(k + 1, k == NB - 1);
    cyc(2);
`ifdef JACOBI_SYM_MIRROR_EN
    chk("lit_ram1",  ram_img[1],  2);
    chk("lit_ram4",  ram_img[4],  2);
    chk("lit_ram5",  ram_img[5],  5);
    chk("lit_ram15", ram_img[15], 10);
`else
    for (int k = 0; k < NB; k++) chk("lit_ram_frame1", ram_img[k], k + 1);
`endif
    chk("lit_done_cnt1", done_cnt, 1);
    chk("lit_full1", mem_full, 1);
    chk("lit_err1", frame_err, 0);

    // Stream pressure while the core owns the RAM.
    wr0 = wr_cnt;
    s_valid = 1; s_data = 'h777;
    cyc(20);
    s_valid = 0;
    chk("lit_no_wr_full", wr_cnt, wr0);
    chk("lit_ready_full", s_ready, 0);
    mem_release = 1; cyc(1); mem_release = 0;
    chk("lit_ready_rel", s_ready, 1);

    // Frame 2: s_last early (beat 7) and missing at the end.
    for (int k = 0; k < NB; k++) begin
      send(100 + k, k == 7);
      if (k == 8) chk("lit_err_early", frame_err, 1);
    end
    cyc(2);
    chk("lit_ram0_frame2", ram_img[0], 100);
    chk("lit_done_cnt2", done_cnt, 2);
    chk("lit_full2", mem_full, 1);
    chk("lit_err_sticky", frame_err, 1);
    mem_release = 1; cyc(1); mem_release = 0;

    // Frame 3: gappy stream, reset after beat 5 while its write is pending.
    for (int k = 0; k < 6; k++) begin
      cyc($urandom_range(0, 2));
      send(200 + k, 0);
    end
    #2 rst_n = 0;
    @(negedge clk);
    chk("lit_rst_ready", s_ready, 0);
    chk("lit_rst_en_a", ram_en_a, 0);
    chk("lit_rst_full", mem_full, 0);
    chk("lit_rst_err", frame_err, 0);
    chk("lit_rst_done", frame_done, 0);
    cyc(1);
    rst_n = 1;
    send(300, NB == 1);
    chk("lit_restart_en", ram_en_a, 1);
    chk("lit_restart_addr", ram_addr_a, 0);
    chk("lit_restart_din", ram_din_a, 300);
    for (int k = 1; k < NB; k++) send(300 + k, k == NB - 1);
    cyc(2);
    chk("lit_done_cnt3", done_cnt, 3);
    chk("lit_err3", frame_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
